// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V memory stage.
// The optional misaligned-access trap is enabled with MEM_MISALIGN_TRAP_EN.
package riscv_pkg;

    localparam int XLEN = 32;

    // Access size, encoded as funct3[1:0]
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    // Memory-stage sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        WAIT_RV  = 2'b10
    } lsu_state_t;

    // The reserved size encoding 11 behaves as a word access
    function automatic mem_size_t decode_size(input logic [1:0] f);
        case (f)
            2'b00:   decode_size = MEM_B;
            2'b01:   decode_size = MEM_H;
            default: decode_size = MEM_W;
        endcase
    endfunction

    // True when the byte offset is not naturally aligned for the size
    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            MEM_H:   is_misaligned = off[0];
            MEM_W:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Clears the offset bits that would make the access misaligned
    function automatic logic [1:0] align_off(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            MEM_B:   align_off = off;
            MEM_H:   align_off = {off[1], 1'b0};
            default: align_off = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and byte/half extraction plus extension for loads.
// Purely combinational; offsets are assumed already aligned for the size.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_size_t        st_size_i,
    input  logic [1:0]       st_off_i,
    input  logic [XLEN-1:0]  st_data_i,
    output logic [3:0]       st_be_o,
    output logic [XLEN-1:0]  st_wdata_o,
    input  mem_size_t        ld_size_i,
    input  logic             ld_unsigned_i,
    input  logic [1:0]       ld_off_i,
    input  logic [XLEN-1:0]  ld_rdata_i,
    output logic [XLEN-1:0]  ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store path: replicate the datum across lanes and enable only the target lanes
    always_comb begin
        st_be_o    = 4'hF;
        st_wdata_o = st_data_i;
        case (st_size_i)
            MEM_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_H: begin
                st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'hF;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    // Load path: pick the addressed byte/half, then sign- or zero-extend
    always_comb begin
        case (ld_off_i)
            2'b00:   ld_byte_s = ld_rdata_i[7:0];
            2'b01:   ld_byte_s = ld_rdata_i[15:8];
            2'b10:   ld_byte_s = ld_rdata_i[23:16];
            default: ld_byte_s = ld_rdata_i[31:24];
        endcase
        if (ld_off_i[1]) begin
            ld_half_s = ld_rdata_i[31:16];
        end else begin
            ld_half_s = ld_rdata_i[15:0];
        end
        case (ld_size_i)
            MEM_B:   ld_data_o = ld_unsigned_i ? {24'h000000, ld_byte_s}
                                               : {{24{ld_byte_s[7]}}, ld_byte_s};
            MEM_H:   ld_data_o = ld_unsigned_i ? {16'h0000, ld_half_s}
                                               : {{16{ld_half_s[15]}}, ld_half_s};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage RISC-V pipeline: req/gnt/rvalid data-memory
// sequencer, request latch and registered MEM/WB outputs.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mem_stage_lsu #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 rf_we_i,
    input  logic                 mem_we_i,
    input  logic                 mem2rf_i,
    input  logic [1:0]           mem_size_i,
    input  logic                 mem_unsigned_i,
    input  logic [XLEN-1:0]      mem_wdata_i,
    input  logic [RF_ADDR_W-1:0] rf_waddr_i,
    input  logic [XLEN-1:0]      alu_result_i,
    output logic                 stall_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    output logic                 wb_valid_o,
    output logic                 rf_we_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic                 misalign_o
);
    import riscv_pkg::*;

    lsu_state_t             state_r, state_nxt_s;
    mem_size_t              size_s;
    logic [1:0]             off_s;
    logic                   is_mem_s, is_store_s, misalign_s, issue_s;
    logic [3:0]             st_be_s;
    logic [XLEN-1:0]        st_wdata_s, ld_data_s;

    // Latched copy of the request, held until the access finishes
    logic                   lat_we_r, lat_unsigned_r, lat_rf_we_r;
    mem_size_t              lat_size_r;
    logic [1:0]             lat_off_r;
    logic [3:0]             lat_be_r;
    logic [XLEN-1:0]        lat_wdata_r, lat_alu_r;
    logic [RF_ADDR_W-1:0]   lat_waddr_r;

    assign size_s     = decode_size(mem_size_i);
    assign is_mem_s   = valid_i & (mem_we_i | mem2rf_i);
    assign is_store_s = mem_we_i;
    assign issue_s    = is_mem_s & ~misalign_s;

    // Misaligned handling: trap, or silently align the offset down
    always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_s = is_misaligned(size_s, alu_result_i[1:0]);
        off_s      = alu_result_i[1:0];
`else
        misalign_s = 1'b0;
        off_s      = align_off(size_s, alu_result_i[1:0]);
`endif
    end

    lsu_align u_align (
        .st_size_i     (size_s),
        .st_off_i      (off_s),
        .st_data_i     (mem_wdata_i),
        .st_be_o       (st_be_s),
        .st_wdata_o    (st_wdata_s),
        .ld_size_i     (lat_size_r),
        .ld_unsigned_i (lat_unsigned_r),
        .ld_off_i      (lat_off_r),
        .ld_rdata_i    (dmem_rdata_i),
        .ld_data_o     (ld_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    if (!dmem_gnt_i) begin
                        state_nxt_s = WAIT_GNT;
                    end else if (is_store_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_RV;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_GNT: begin
                if (!dmem_gnt_i) begin
                    state_nxt_s = WAIT_GNT;
                end else if (lat_we_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RV;
                end
            end
            WAIT_RV: begin
                if (dmem_rvalid_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RV;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory port and stall outputs; IDLE drives straight from EX/MEM, WAIT_GNT from the latch
    always_comb begin
        stall_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = {XLEN{1'b0}};
        dmem_be_o    = 4'h0;
        dmem_wdata_o = {XLEN{1'b0}};
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = is_store_s;
                    dmem_addr_o  = {alu_result_i[XLEN-1:2], 2'b00};
                    dmem_be_o    = st_be_s;
                    dmem_wdata_o = st_wdata_s;
                    stall_o      = ~is_store_s | ~dmem_gnt_i;
                end else begin
                    stall_o      = 1'b0;
                end
            end
            WAIT_GNT: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = lat_we_r;
                dmem_addr_o  = {lat_alu_r[XLEN-1:2], 2'b00};
                dmem_be_o    = lat_be_r;
                dmem_wdata_o = lat_wdata_r;
                stall_o      = ~lat_we_r | ~dmem_gnt_i;
            end
            WAIT_RV: stall_o = ~dmem_rvalid_i;
            default: stall_o = 1'b0;
        endcase
    end

    // Capture the request when it is first issued from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we_r       <= 1'b0;
            lat_unsigned_r <= 1'b0;
            lat_rf_we_r    <= 1'b0;
            lat_size_r     <= MEM_B;
            lat_off_r      <= 2'b00;
            lat_be_r       <= 4'h0;
            lat_wdata_r    <= {XLEN{1'b0}};
            lat_alu_r      <= {XLEN{1'b0}};
            lat_waddr_r    <= {RF_ADDR_W{1'b0}};
        end else if ((state_r == IDLE) && issue_s) begin
            lat_we_r       <= is_store_s;
            lat_unsigned_r <= mem_unsigned_i;
            lat_rf_we_r    <= rf_we_i & ~is_store_s;
            lat_size_r     <= size_s;
            lat_off_r      <= off_s;
            lat_be_r       <= st_be_s;
            lat_wdata_r    <= st_wdata_s;
            lat_alu_r      <= alu_result_i;
            lat_waddr_r    <= rf_waddr_i;
        end else begin
            lat_we_r       <= lat_we_r;
        end
    end

    // MEM/WB registers: load on op completion, otherwise insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= {RF_ADDR_W{1'b0}};
            rf_wdata_o <= {XLEN{1'b0}};
            misalign_o <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            rf_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_i && (!is_mem_s || misalign_s || (is_store_s && dmem_gnt_i))) begin
                        wb_valid_o <= 1'b1;
                        rf_we_o    <= rf_we_i & ~is_mem_s;
                        misalign_o <= is_mem_s & misalign_s;
                        rf_waddr_o <= rf_waddr_i;
                        rf_wdata_o <= alu_result_i;
                    end
                end
                WAIT_GNT: begin
                    if (lat_we_r && dmem_gnt_i) begin
                        wb_valid_o <= 1'b1;
                        rf_waddr_o <= lat_waddr_r;
                        rf_wdata_o <= lat_alu_r;
                    end
                end
                WAIT_RV: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        rf_we_o    <= lat_rf_we_r;
                        rf_waddr_o <= lat_waddr_r;
                        rf_wdata_o <= ld_data_s;
                    end
                end
                default: wb_valid_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the following edge.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, rf_we_i, mem_we_i, mem2rf_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_wdata_i, rf_waddr_i, alu_result_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, rf_we_o, misalign_o;
    logic [31:0] rf_waddr_o, rf_wdata_o;

    int checks   = 0;
    int failures = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .rf_we_i(rf_we_i),
        .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_wdata_i(mem_wdata_i),
        .rf_waddr_i(rf_waddr_i), .alu_result_i(alu_result_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rfwe, input logic we, input logic ld,
                          input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                          input logic [31:0] wa, input logic [31:0] alu);
        valid_i = v; rf_we_i = rfwe; mem_we_i = we; mem2rf_i = ld;
        mem_size_i = sz; mem_unsigned_i = uns; mem_wdata_i = wd;
        rf_waddr_i = wa; alu_result_i = alu;
    endtask

    // Load with immediate grant, rvalid after rv_wait empty WAIT_RV cycles
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data,
                            input int rv_wait);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, sz, uns, 32'h0, 32'd9, addr);
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        #1;
        chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({tag, "_addr"}, dmem_addr_o, exp_addr);
        chk({tag, "_stall0"}, {31'd0, stall_o}, 32'd1);
        tick();
        chk({tag, "_bubble0"}, {31'd0, wb_valid_o}, 32'd0);
        dmem_gnt_i = 1'b0;
        for (int j = 0; j < rv_wait; j++) begin
            #1;
            chk({tag, "_stallw"}, {31'd0, stall_o}, 32'd1);
            chk({tag, "_reqw"}, {31'd0, dmem_req_o}, 32'd0);
            tick();
            chk({tag, "_bubblew"}, {31'd0, wb_valid_o}, 32'd0);
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        #1;
        chk({tag, "_stallrv"}, {31'd0, stall_o}, 32'd0);
        tick();
        chk({tag, "_wbv"}, {31'd0, wb_valid_o}, 32'd1);
        chk({tag, "_rfwe"}, {31'd0, rf_we_o}, 32'd1);
        chk({tag, "_waddr"}, rf_waddr_o, 32'd9);
        chk({tag, "_data"}, rf_wdata_o, exp_data);
        dmem_rvalid_i = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        #2;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_rfwe", {31'd0, rf_we_o}, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. ALU op passes through in one cycle
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'd5, 32'h1234);
        #1;
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        chk("alu_req", {31'd0, dmem_req_o}, 32'd0);
        tick();
        chk("alu_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("alu_rfwe", {31'd0, rf_we_o}, 32'd1);
        chk("alu_waddr", rf_waddr_o, 32'd5);
        chk("alu_wdata", rf_wdata_o, 32'h1234);
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd6, 32'h55);
        tick();
        chk("invalid_bubble", {31'd0, wb_valid_o}, 32'd0);
        chk("invalid_rfwe", {31'd0, rf_we_o}, 32'd0);

        // 2. SB at 0x103, grant after 3 waiting cycles (rvalid noise on the grant cycle)
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h123456AB, 32'd3, 32'h103);
        for (int i = 0; i < 4; i++) begin
            dmem_gnt_i = (i == 3);
            dmem_rvalid_i = (i == 3);
            #1;
            chk("sb_req", {31'd0, dmem_req_o}, 32'd1);
            chk("sb_we", {31'd0, dmem_we_o}, 32'd1);
            chk("sb_addr", dmem_addr_o, 32'h100);
            chk("sb_be", {28'd0, dmem_be_o}, 32'h8);
            chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
            chk("sb_stall", {31'd0, stall_o}, (i < 3) ? 32'd1 : 32'd0);
            tick();
            chk("sb_wbv", {31'd0, wb_valid_o}, (i < 3) ? 32'd0 : 32'd1);
        end
        chk("sb_rfwe", {31'd0, rf_we_o}, 32'd0);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("sb_done_req", {31'd0, dmem_req_o}, 32'd0);
        tick();

        // SH at 0x206 with immediate grant
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h1234BEEF, 32'd0, 32'h206);
        dmem_gnt_i = 1'b1;
        #1;
        chk("sh_be", {28'd0, dmem_be_o}, 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'hBEEFBEEF);
        chk("sh_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("sh_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("sh_rfwe", {31'd0, rf_we_o}, 32'd0);
        dmem_gnt_i = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();

        // 3. Half/byte loads with sign and zero extension
        run_load("lh",  32'h202, 2'b01, 1'b0, 32'h80010000, 32'h200, 32'hFFFF8001, 1);
        run_load("lhu", 32'h202, 2'b01, 1'b1, 32'h80010000, 32'h200, 32'h00008001, 1);
        run_load("lb",  32'h212, 2'b00, 1'b0, 32'h12FE3456, 32'h210, 32'hFFFFFFFE, 0);
        run_load("lbu", 32'h212, 2'b00, 1'b1, 32'h12FE3456, 32'h210, 32'h000000FE, 2);

        // 4. Reset while waiting for rvalid; late rvalid must be ignored
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'd4, 32'h400);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        chk("rst4_waitrv_stall", {31'd0, stall_o}, 32'd1);
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst4_stall", {31'd0, stall_o}, 32'd0);
        chk("rst4_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst4_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("rst4_wdata", rf_wdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD0001;
        #1;
        chk("rst4_late_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("rst4_late_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("rst4_late_rfwe", {31'd0, rf_we_o}, 32'd0);
        chk("rst4_late_wdata", rf_wdata_o, 32'h0);
        dmem_rvalid_i = 1'b0;

        // 5. Misaligned LW at 0x301
`ifdef MEM_MISALIGN_TRAP_EN
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'd8, 32'h301);
        dmem_gnt_i = 1'b1;
        #1;
        chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("mis_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("mis_rfwe", {31'd0, rf_we_o}, 32'd0);
        dmem_gnt_i = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("mis_clear", {31'd0, misalign_o}, 32'd0);
`else
        run_load("lw_mis", 32'h301, 2'b10, 1'b0, 32'hA5A55A5A, 32'h300, 32'hA5A55A5A, 1);
        chk("mis_flag", {31'd0, misalign_o}, 32'd0);
`endif

        // 6. Back-to-back SW, LW, ALU with gnt/rvalid always high
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 32'h500);
        #1;
        chk("b2b_sw_stall", {31'd0, stall_o}, 32'd0);
        chk("b2b_sw_be", {28'd0, dmem_be_o}, 32'hF);
        chk("b2b_sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        tick();
        chk("b2b_sw_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("b2b_sw_rfwe", {31'd0, rf_we_o}, 32'd0);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'd12, 32'h504);
        #1;
        chk("b2b_lw_stall", {31'd0, stall_o}, 32'd1);
        chk("b2b_lw_addr", dmem_addr_o, 32'h504);
        tick();
        chk("b2b_lw_bubble", {31'd0, wb_valid_o}, 32'd0);
        #1;
        chk("b2b_rv_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("b2b_lw_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("b2b_lw_rfwe", {31'd0, rf_we_o}, 32'd1);
        chk("b2b_lw_waddr", rf_waddr_o, 32'd12);
        chk("b2b_lw_data", rf_wdata_o, 32'hCAFEF00D);
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd13, 32'h77);
        #1;
        chk("b2b_alu_stall", {31'd0, stall_o}, 32'd0);
        tick();
        chk("b2b_alu_wbv", {31'd0, wb_valid_o}, 32'd1);
        chk("b2b_alu_data", rf_wdata_o, 32'h77);
        chk("b2b_alu_waddr", rf_waddr_o, 32'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
